door_ctrl_gen2: RTL and testbench

Second-generation door/gate motor controller with runtime protections.
- Drives a single reversible motor from up/down/stop keys and end-position sensors.
- Adds obstacle handling, motor dead-time on direction change, drive timeout with fault latch, and a blinking warning light.
- Sits between the synchronised key/sensor inputs and the motor driver/indicator outputs of the door subsystem.

---
 rtl/door_pkg.sv | 36 +++
 rtl/door_blink.sv | 46 ++++
 rtl/door_ctrl_gen2.sv | 170 +++++++++++++++++
 tb/tb_door_ctrl_gen2.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/door_pkg.sv
// door_pkg: shared state/direction types and width helpers for the
// door controller (state_t, dir_t, cnt_w, max_w, is_blink).
package door_pkg;

    typedef enum logic [2:0] {
        ST_START_UP  = 3'd0,
        ST_IS_OPEN   = 3'd1,
        ST_IS_CLOSED = 3'd2,
        ST_STOPPED   = 3'd3,
        ST_DRV_OPEN  = 3'd4,
        ST_DRV_CLOSE = 3'd5,
        ST_PAUSE     = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    typedef enum logic {
        DIR_OPEN  = 1'b0,
        DIR_CLOSE = 1'b1
    } dir_t;

    // Bits needed to hold the values 0..max_val (at least 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // States in which the red light blinks instead of being steady.
    function automatic logic is_blink(input state_t s);
        return (s == ST_DRV_OPEN) || (s == ST_DRV_CLOSE) ||
               (s == ST_PAUSE) || (s == ST_FAULT);
    endfunction

endpackage

// File: rtl/door_blink.sv
// door_blink: BLINK_DIV half-period divider for the warning light.
// Ports: clk2m, rst_n, restart (sync, phase restarts high), phase out.
module door_blink
    import door_pkg::*;
#(
    parameter int BLINK_DIV = 500_000
) (
    input  logic clk2m,
    input  logic rst_n,
    input  logic restart,
    output logic phase
);

    localparam int CW = cnt_w(BLINK_DIV - 1);
    localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          phase_q;
    logic          phase_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/door_ctrl_gen2.sv
// door_ctrl_gen2: reversible door motor controller with obstacle
// reversal, direction dead-time, drive timeout/fault latch and blink.
// Ports: clk2m, rst_n, key_up/down/stop, sense_up/down, obstacle in;
// ml (close), mr (open), light_red, light_green, fault out.
// All outputs are a decode of registered state and counters only.
module door_ctrl_gen2
    import door_pkg::*;
#(
    parameter int TIMEOUT_CYC         = 2_000_000,
    parameter int PAUSE_CYC           = 200_000,
    parameter int BLINK_DIV           = 500_000,
    parameter int REVERSE_ON_OBSTACLE = 1
) (
    input  logic clk2m,
    input  logic rst_n,
    input  logic key_up,
    input  logic key_down,
    input  logic key_stop,
    input  logic sense_up,
    input  logic sense_down,
    input  logic obstacle,
    output logic ml,
    output logic mr,
    output logic light_red,
    output logic light_green,
    output logic fault
);

    // One counter serves both the drive timeout and the pause dead-time;
    // it is cleared on every state change so the two never overlap.
    localparam int CW = max_w(cnt_w(TIMEOUT_CYC), cnt_w(PAUSE_CYC));
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] PS_LAST = CW'(PAUSE_CYC - 1);
    localparam logic REVERSE = (REVERSE_ON_OBSTACLE != 0);

    state_t        state_q;
    state_t        state_d;
    dir_t          tgt_q;
    dir_t          tgt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic conflict;
    logic timeout;
    logic pause_done;
    logic only_up;
    logic only_down;
    logic blink_restart;
    logic blink_ph;

    assign conflict   = sense_up & sense_down;
    // cnt_q holds how many motor-on cycles already elapsed before this one.
    assign timeout    = (cnt_q == TO_LAST);
    assign pause_done = (cnt_q == PS_LAST);
    assign only_up    = key_up & ~key_down;
    assign only_down  = key_down & ~key_up;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        if (conflict && (state_q != ST_FAULT)) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                ST_START_UP: begin
                    if (sense_down)    state_d = ST_IS_CLOSED;
                    else if (sense_up) state_d = ST_IS_OPEN;
                    else if (key_up)   state_d = ST_DRV_OPEN;
                    else if (key_down) state_d = ST_DRV_CLOSE;
                end
                ST_IS_CLOSED: begin
                    if (only_up) state_d = ST_DRV_OPEN;
                end
                ST_IS_OPEN: begin
                    if (only_down) state_d = ST_DRV_CLOSE;
                end
                ST_STOPPED: begin
                    if (only_up)        state_d = ST_DRV_OPEN;
                    else if (only_down) state_d = ST_DRV_CLOSE;
                end
                ST_DRV_OPEN: begin
                    if (key_stop)      state_d = ST_STOPPED;
                    else if (sense_up) state_d = ST_IS_OPEN;
                    else if (timeout)  state_d = ST_FAULT;
                    else if (key_down) begin
                        state_d = ST_PAUSE;
                        tgt_d   = DIR_CLOSE;
                    end
                end
                ST_DRV_CLOSE: begin
                    if (key_stop)        state_d = ST_STOPPED;
                    else if (sense_down) state_d = ST_IS_CLOSED;
                    else if (timeout)    state_d = ST_FAULT;
                    else if (obstacle) begin
                        if (REVERSE) begin
                            state_d = ST_PAUSE;
                            tgt_d   = DIR_OPEN;
                        end else begin
                            state_d = ST_STOPPED;
                        end
                    end else if (key_up) begin
                        state_d = ST_PAUSE;
                        tgt_d   = DIR_OPEN;
                    end
                end
                ST_PAUSE: begin
                    if (key_stop) begin
                        state_d = ST_STOPPED;
                    end else if (pause_done) begin
                        state_d = (tgt_q == DIR_OPEN) ? ST_DRV_OPEN
                                                      : ST_DRV_CLOSE;
                    end
                end
                ST_FAULT: begin
                    if (key_stop) state_d = ST_START_UP;
                end
                default: state_d = ST_START_UP;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_DRV_OPEN) ||
                     (state_q == ST_DRV_CLOSE) ||
                     (state_q == ST_PAUSE)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Every entry into a blinking state starts with a full "on" half-period.
    assign blink_restart = (state_d != state_q) && is_blink(state_d);

    always_ff @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START_UP;
            tgt_q   <= DIR_OPEN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    door_blink #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk2m   (clk2m),
        .rst_n   (rst_n),
        .restart (blink_restart),
        .phase   (blink_ph)
    );

    always_comb begin
        ml          = (state_q == ST_DRV_CLOSE);
        mr          = (state_q == ST_DRV_OPEN);
        light_green = (state_q == ST_IS_OPEN);
        fault       = (state_q == ST_FAULT);
        if (is_blink(state_q)) begin
            light_red = blink_ph;
        end else begin
            light_red = (state_q == ST_IS_CLOSED) ||
                        (state_q == ST_STOPPED);
        end
    end

endmodule

// File: tb/tb_door_ctrl_gen2.sv
// tb_door_ctrl_gen2: directed bench for door_ctrl_gen2 with a reversing
// and a non-reversing instance, each checked against a rule model.
module tb_door_ctrl_gen2;

    localparam int TO = 20;
    localparam int PC = 4;
    localparam int BD = 3;

    typedef enum logic [3:0] {
        M_START, M_OPEN, M_CLOSED, M_STOP,
        M_DOPEN, M_DCLOSE, M_PAUSE, M_FAULT
    } ms_e;

    typedef struct packed {
        ms_e st;
        ms_e tgt;
        int  age;
    } mdl_t;

    localparam mdl_t M_RST = '{st: M_START, tgt: M_DOPEN, age: 0};

    logic clk2m = 1'b0;
    logic rst_n = 1'b0;
    logic key_up = 1'b0;
    logic key_down = 1'b0;
    logic key_stop = 1'b0;
    logic sense_up = 1'b0;
    logic sense_down = 1'b0;
    logic obstacle = 1'b0;

    logic ml1, mr1, red1, grn1, flt1;
    logic ml0, mr0, red0, grn0, flt0;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    mdl_t m1 = M_RST;
    mdl_t m0 = M_RST;

    always #5 clk2m = ~clk2m;

    door_ctrl_gen2 #(
        .TIMEOUT_CYC(TO), .PAUSE_CYC(PC), .BLINK_DIV(BD),
        .REVERSE_ON_OBSTACLE(1)
    ) u_rev (
        .clk2m(clk2m), .rst_n(rst_n),
        .key_up(key_up), .key_down(key_down), .key_stop(key_stop),
        .sense_up(sense_up), .sense_down(sense_down),
        .obstacle(obstacle),
        .ml(ml1), .mr(mr1), .light_red(red1),
        .light_green(grn1), .fault(flt1)
    );

    door_ctrl_gen2 #(
        .TIMEOUT_CYC(TO), .PAUSE_CYC(PC), .BLINK_DIV(BD),
        .REVERSE_ON_OBSTACLE(0)
    ) u_stop (
        .clk2m(clk2m), .rst_n(rst_n),
        .key_up(key_up), .key_down(key_down), .key_stop(key_stop),
        .sense_up(sense_up), .sense_down(sense_down),
        .obstacle(obstacle),
        .ml(ml0), .mr(mr0), .light_red(red0),
        .light_green(grn0), .fault(flt0)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Next model state from the behavioural rules; age = cycles spent
    // in the current state before this edge.
    function automatic mdl_t step(input mdl_t m, input logic ku,
                                  input logic kd, input logic ks,
                                  input logic su, input logic sd,
                                  input logic ob, input bit rev);
        mdl_t n = m;
        ms_e nx = m.st;
        if (su && sd && m.st != M_FAULT) begin
            nx = M_FAULT;
        end else begin
            case (m.st)
                M_START:
                    if (sd) nx = M_CLOSED;
                    else if (su) nx = M_OPEN;
                    else if (ku) nx = M_DOPEN;
                    else if (kd) nx = M_DCLOSE;
                M_CLOSED: if (ku && !kd) nx = M_DOPEN;
                M_OPEN:   if (kd && !ku) nx = M_DCLOSE;
                M_STOP:
                    if (ku && !kd) nx = M_DOPEN;
                    else if (kd && !ku) nx = M_DCLOSE;
                M_DOPEN:
                    if (ks) nx = M_STOP;
                    else if (su) nx = M_OPEN;
                    else if (m.age + 1 >= TO) nx = M_FAULT;
                    else if (kd) begin nx = M_PAUSE; n.tgt = M_DCLOSE; end
                M_DCLOSE:
                    if (ks) nx = M_STOP;
                    else if (sd) nx = M_CLOSED;
                    else if (m.age + 1 >= TO) nx = M_FAULT;
                    else if (ob && rev) begin nx = M_PAUSE; n.tgt = M_DOPEN; end
                    else if (ob) nx = M_STOP;
                    else if (ku) begin nx = M_PAUSE; n.tgt = M_DOPEN; end
                M_PAUSE:
                    if (ks) nx = M_STOP;
                    else if (m.age + 1 >= PC) nx = m.tgt;
                M_FAULT: if (ks) nx = M_START;
                default: nx = M_START;
            endcase
        end
        n.st = nx;
        n.age = (nx != m.st) ? 0 : m.age + 1;
        return n;
    endfunction

    // Expected {ml, mr, red, green, fault}.
    function automatic int outs(input mdl_t m);
        logic blink;
        logic red;
        blink = (m.st == M_DOPEN) || (m.st == M_DCLOSE) ||
                (m.st == M_PAUSE) || (m.st == M_FAULT);
        if (blink) red = ((m.age / BD) % 2) == 0;
        else red = (m.st == M_CLOSED) || (m.st == M_STOP);
        return int'({m.st == M_DCLOSE, m.st == M_DOPEN, red,
                     m.st == M_OPEN, m.st == M_FAULT});
    endfunction

    always @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= M_RST;
            m0 <= M_RST;
        end else begin
            m1 <= step(m1, key_up, key_down, key_stop,
                       sense_up, sense_down, obstacle, 1'b1);
            m0 <= step(m0, key_up, key_down, key_stop,
                       sense_up, sense_down, obstacle, 1'b0);
        end
    end

    always @(negedge clk2m) begin
        if (chk_on && rst_n) begin
            chk("u_rev outs", int'({ml1, mr1, red1, grn1, flt1}), outs(m1));
            chk("u_stop outs", int'({ml0, mr0, red0, grn0, flt0}), outs(m0));
        end
    end

    always @(negedge clk2m) begin
        if (rst_n) begin
            assert (!(ml1 && mr1)) else $error("FAIL u_rev ml and mr both high");
            assert (!(ml0 && mr0)) else $error("FAIL u_stop ml and mr both high");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic su, input logic sd);
        rst_n = 1'b0;
        key_up = 1'b0;
        key_down = 1'b0;
        key_stop = 1'b0;
        obstacle = 1'b0;
        sense_up = 1'b0;
        sense_down = 1'b0;
        @(negedge clk2m);
        sense_up = su;
        sense_down = sd;
        rst_n = 1'b1;
        @(negedge clk2m);
    endtask

    initial begin
        logic [9:0] exp_red;
        int gap;
        int on;
        int n;
        exp_red = 10'b1110001110;

        repeat (2) @(negedge clk2m);
        chk("reset outs rev", int'({ml1, mr1, red1, grn1, flt1}), 0);
        chk("reset outs stop", int'({ml0, mr0, red0, grn0, flt0}), 0);

        sense_down = 1'b1;
        rst_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clk2m);
        chk("closed red", red1, 1);
        chk("closed motors", int'({ml1, mr1}), 0);

        sense_down = 1'b0;
        key_up = 1'b1;
        @(negedge clk2m);
        key_up = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("drive open mr", mr1, 1);
            chk("drive open red", red1, int'(exp_red[9-i]));
            if (i == 9) sense_up = 1'b1;
            @(negedge clk2m);
        end
        chk("open green", grn1, 1);
        chk("open mr off", mr1, 0);

        sense_up = 1'b0;
        key_down = 1'b1;
        @(negedge clk2m);
        key_down = 1'b0;
        chk("close ml rev", ml1, 1);
        chk("close ml stop", ml0, 1);
        @(negedge clk2m);
        obstacle = 1'b1;
        @(negedge clk2m);
        obstacle = 1'b0;
        gap = 0;
        n = 0;
        while (!mr1 && n < 20) begin
            if (!ml1) gap++;
            chk("no-reverse red steady", red0, 1);
            chk("no-reverse ml off", ml0, 0);
            @(negedge clk2m);
            n++;
        end
        chk("obstacle gap", gap, PC);
        chk("obstacle reverse mr", mr1, 1);

        on = 0;
        n = 0;
        while (!flt1 && n < 60) begin
            if (mr1) on++;
            @(negedge clk2m);
            n++;
        end
        chk("timeout mr cycles", on, TO);
        chk("timeout fault", flt1, 1);
        chk("fault motors", int'({ml1, mr1}), 0);
        key_stop = 1'b1;
        @(negedge clk2m);
        key_stop = 1'b0;
        chk("fault ack outs", int'({ml1, mr1, red1, grn1, flt1}), 0);
        chk("stopped unit red", red0, 1);

        do_reset(1'b1, 1'b0);
        chk("open after reset", grn1, 1);
        sense_down = 1'b1;
        @(negedge clk2m);
        chk("conflict fault", flt1, 1);
        chk("conflict green off", grn1, 0);
        sense_up = 1'b0;
        sense_down = 1'b0;
        @(negedge clk2m);
        chk("fault sticky", flt1, 1);
        key_stop = 1'b1;
        @(negedge clk2m);
        key_stop = 1'b0;
        chk("fault cleared", flt1, 0);

        key_down = 1'b1;
        @(negedge clk2m);
        key_down = 1'b0;
        chk("startup close ml", ml1, 1);
        @(negedge clk2m);
        key_stop = 1'b1;
        sense_down = 1'b1;
        @(negedge clk2m);
        key_stop = 1'b0;
        sense_down = 1'b0;
        chk("stop wins ml", ml1, 0);
        chk("stop wins red", red1, 1);
        key_up = 1'b1;
        key_down = 1'b1;
        @(negedge clk2m);
        chk("both keys ignored", int'({ml1, mr1}), 0);
        key_up = 1'b0;
        @(negedge clk2m);
        key_down = 1'b0;
        chk("stopped accepts close", ml1, 1);

        key_up = 1'b1;
        @(negedge clk2m);
        key_up = 1'b0;
        gap = 0;
        n = 0;
        while (!mr1 && n < 20) begin
            if (!ml1) gap++;
            @(negedge clk2m);
            n++;
        end
        chk("reversal gap", gap, PC);
        chk("reversal mr", mr1, 1);

        rst_n = 1'b0;
        #1;
        chk("async reset mr", mr1, 0);
        chk("async reset red", red1, 0);
        @(negedge clk2m);
        rst_n = 1'b1;
        @(negedge clk2m);
        chk("restart outs", int'({ml1, mr1, red1, grn1, flt1}), 0);
        repeat (3) @(negedge clk2m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
